// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants for the MIPS32 core.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Next-PC priority mux: jr > taken branch > j/jal > sequential, all word aligned.
module ifetch_next_pc
    import cpu_pkg::*;
(
    input  logic [31:0] opcplus4_i,
    input  logic [25:0] jidx_i,
    input  logic        branch_i,
    input  logic        nbranch_i,
    input  logic        jmp_i,
    input  logic        jal_i,
    input  logic        jrn_i,
    input  logic        zero_i,
    input  logic [31:0] add_result_i,
    input  logic [31:0] read_data_1_i,
    output logic [31:0] next_pc_o
);

    always_comb begin
        next_pc_o = opcplus4_i;
        if (jrn_i) begin
            next_pc_o = align_word(read_data_1_i);
        end else if ((branch_i & zero_i) | (nbranch_i & ~zero_i)) begin
            next_pc_o = align_word(add_result_i);
        end else if (jmp_i | jal_i) begin
            // j/jal stay inside the 256 MB region of the delay-slot address
            next_pc_o = {opcplus4_i[31:28], jidx_i, 2'b00};
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, req/ready fetch FSM, issue/stall hold and retire counter.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             Branch,
    input  logic             nBranch,
    input  logic             Jmp,
    input  logic             Jal,
    input  logic             Jrn,
    input  logic             Zero,
    input  logic [31:0]      Add_result,
    input  logic [31:0]      Read_data_1,
    output logic [31:0]      Instruction,
    output logic             instr_valid,
    output logic [31:0]      opcplus4,
    output logic [31:0]      pc_out,
    output logic [CNT_W-1:0] instr_count
);

    fetch_state_t     state_q;
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      opcplus4_q;
    logic [31:0]      instr_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;

    ifetch_next_pc u_next_pc (
        .opcplus4_i    (opcplus4_q),
        .jidx_i        (instr_q[25:0]),
        .branch_i      (Branch),
        .nbranch_i     (nBranch),
        .jmp_i         (Jmp),
        .jal_i         (Jal),
        .jrn_i         (Jrn),
        .zero_i        (Zero),
        .add_result_i  (Add_result),
        .read_data_1_i (Read_data_1),
        .next_pc_o     (pc_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            opcplus4_q <= RESET_PC + 32'd4;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                FETCH, WAIT: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_q       <= pc_d;
                        opcplus4_q <= pc_d + 32'd4;
                        count_q    <= count_q + CNT_W'(1);
                        valid_q    <= 1'b0;
                        state_q    <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Request is dropped immediately on reset so an in-flight access is aborted.
    assign imem_req    = (state_q != ISSUE) & ~reset;
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign instr_valid = valid_q;
    assign opcplus4    = opcplus4_q;
    assign pc_out      = pc_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed cases plus randomized fetch/stall/redirect traffic.
module tb_ifetch_unit;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Branch, nBranch, Jmp, Jal, Jrn, Zero;
    logic [31:0] Add_result, Read_data_1;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic [31:0] opcplus4;
    logic [31:0] pc_out;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jrn         (Jrn),
        .Zero        (Zero),
        .Add_result  (Add_result),
        .Read_data_1 (Read_data_1),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .opcplus4    (opcplus4),
        .pc_out      (pc_out),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference next-PC from the architectural rules.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic br, input logic nbr, input logic jmp,
                                             input logic jal, input logic jrn, input logic z,
                                             input logic [31:0] add, input logic [31:0] rd1);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jrn) return rd1 & 32'hFFFF_FFFC;
        if ((br && z) || (nbr && !z)) return add & 32'hFFFF_FFFC;
        if (jmp || jal) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
        return seq;
    endfunction

    task automatic junk_ctl();
        Branch      = 1'($urandom);
        nBranch     = 1'($urandom);
        Jmp         = 1'($urandom);
        Jal         = 1'($urandom);
        Jrn         = 1'($urandom);
        Zero        = 1'($urandom);
        Add_result  = $urandom;
        Read_data_1 = $urandom;
    endtask

    task automatic clear_ctl();
        {Branch, nBranch, Jmp, Jal, Jrn, Zero} = '0;
        Add_result  = '0;
        Read_data_1 = '0;
        stall       = 1'b0;
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge after retire.
    task automatic run_instr(input int waits, input int stalls, input logic [31:0] word,
                             input logic br, input logic nbr, input logic jmp, input logic jal,
                             input logic jrn, input logic z,
                             input logic [31:0] add, input logic [31:0] rd1);
        for (int w = 0; w <= waits; w++) begin
            chk("fetch_req", {31'd0, imem_req}, 32'd1);
            chk("fetch_addr", imem_addr, m_pc);
            chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
            imem_ready = (w == waits);
            imem_rdata = (w == waits) ? word : $urandom;
            stall      = 1'($urandom);
            junk_ctl();
            @(negedge clock);
        end
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        for (int s = 0; s <= stalls; s++) begin
            chk("issue_valid", {31'd0, instr_valid}, 32'd1);
            chk("issue_instr", Instruction, word);
            chk("issue_opc4", opcplus4, m_pc + 32'd4);
            chk("issue_pc", pc_out, m_pc);
            chk("issue_cnt", instr_count, m_cnt);
            chk("issue_req", {31'd0, imem_req}, 32'd0);
            if (s < stalls) begin
                stall = 1'b1;
                junk_ctl();
                if (s == stalls / 2) Jmp = 1'b1;
            end else begin
                stall       = 1'b0;
                Branch      = br;
                nBranch     = nbr;
                Jmp         = jmp;
                Jal         = jal;
                Jrn         = jrn;
                Zero        = z;
                Add_result  = add;
                Read_data_1 = rd1;
            end
            @(negedge clock);
        end
        m_pc  = ref_next(m_pc, word, br, nbr, jmp, jal, jrn, z, add, rd1);
        m_cnt = m_cnt + 32'd1;
        clear_ctl();
    endtask

    task automatic seq_instr(input int waits, input int stalls);
        run_instr(waits, stalls, $urandom, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic jr_to(input logic [31:0] tgt);
        run_instr(0, 0, $urandom, 0, 0, 0, 0, 1, 0, 32'd0, tgt);
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        clear_ctl();
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        repeat (2) @(negedge clock);

        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_opc4", opcplus4, 32'h4);
        chk("rst_cnt", instr_count, 32'h0);
        reset = 1'b0;
        #1;

        // zero-wait sequential run
        for (int i = 0; i < 4; i++) seq_instr(0, 0);
        chk("cnt_after4", instr_count, 32'd4);
        chk("pc_after4", imem_addr, 32'h10);

        // three memory wait cycles at 0x10
        seq_instr(3, 0);

        // beq / bne taken and not taken
        jr_to(32'h20);
        run_instr(0, 0, {BEQ, 26'h0}, 1, 0, 0, 0, 0, 1, 32'h40, 32'h0);
        chk("beq_taken", imem_addr, 32'h40);
        jr_to(32'h20);
        run_instr(0, 0, {BEQ, 26'h0}, 1, 0, 0, 0, 0, 0, 32'h40, 32'h0);
        chk("beq_not_taken", imem_addr, 32'h24);
        run_instr(0, 0, {BNE, 26'h0}, 0, 1, 0, 0, 0, 0, 32'h60, 32'h0);
        chk("bne_taken", imem_addr, 32'h60);
        run_instr(0, 0, {BNE, 26'h0}, 0, 1, 0, 0, 0, 1, 32'h80, 32'h0);
        chk("bne_not_taken", imem_addr, 32'h64);

        // jal region concatenation, then jr beats branch and is aligned
        jr_to(32'h3000_0100);
        run_instr(1, 0, {JAL, 26'h000_0010}, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        chk("jal_target", imem_addr, 32'h3000_0040);
        run_instr(0, 0, $urandom, 1, 0, 0, 0, 1, 1, 32'h1000, 32'h83);
        chk("jr_priority", imem_addr, 32'h80);

        // stall with mid-stall jump pulse, then jump held at release
        run_instr(0, 5, {J, 26'h0000_100}, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("stall_seq", imem_addr, 32'h84);
        run_instr(0, 5, {J, 26'h0000_100}, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("stall_jmp", imem_addr, 32'h400);

        // pc wrap at top of address space
        jr_to(32'hFFFF_FFFC);
        seq_instr(0, 0);
        chk("pc_wrap", imem_addr, 32'h0);

        // reset during WAIT with a same-cycle ready
        chk("pre_wait_req", {31'd0, imem_req}, 32'd1);
        @(negedge clock);
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("rstw_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstw_instr", Instruction, 32'h0);
        chk("rstw_addr", imem_addr, 32'h0);
        chk("rstw_req", {31'd0, imem_req}, 32'd0);
        chk("rstw_cnt", instr_count, 32'h0);
        reset      = 1'b0;
        imem_ready = 1'b0;
        m_pc       = 32'h0;
        m_cnt      = 32'h0;
        #1;

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [31:0] word;
            word = $urandom;
            run_instr($urandom_range(3, 0), $urandom_range(3, 0), word,
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(7, 0) == 0), 1'($urandom), $urandom, $urandom);
        end
        chk("final_cnt", instr_count, m_cnt);
        chk("final_addr", imem_addr, m_pc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
